// File: rtl/bmp180_temp_comp.sv
// BMP180 temperature compensation: computes B5 and the true temperature
// (0.1 degC steps) from UT and the AC5/AC6/MC/MD calibration words, using a
// 32-step restoring divider for the single division in the algorithm.
module bmp180_temp_comp (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic        [15:0] ut,
  input  logic        [15:0] ac5,
  input  logic        [15:0] ac6,
  input  logic signed [15:0] mc,
  input  logic signed [15:0] md,
  output logic               busy,
  output logic               done,
  output logic               div_err,
  output logic signed [31:0] b5,
  output logic signed [15:0] temp
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, FIN} state_t;

  state_t state_q;

  logic        [15:0] ut_q;
  logic        [15:0] ac5_q;
  logic        [15:0] ac6_q;
  logic signed [15:0] mc_q;
  logic signed [15:0] md_q;

  logic signed [31:0] x1_q;
  logic signed [31:0] x2_q;
  logic        [31:0] quo_q;
  logic        [31:0] rem_q;
  logic        [31:0] dvs_q;
  logic               negQuo_q;
  logic               zeroDiv_q;
  logic        [4:0]  divCnt_q;

  logic               busy_q;
  logic               done_q;
  logic               divErr_q;
  logic signed [31:0] b5_q;
  logic signed [15:0] temp_q;

  logic signed [16:0] diff_d;
  logic signed [33:0] prod_d;
  logic signed [31:0] x1_d;
  logic signed [31:0] num_d;
  logic signed [31:0] den_d;
  logic        [31:0] numMag_d;
  logic        [31:0] denMag_d;
  logic        [32:0] trial_d;
  logic               fit_d;
  logic signed [31:0] x2_d;
  logic signed [31:0] b5_d;
  logic signed [15:0] temp_d;

  // Datapath: X1 product/shift, divider operands, one restoring step, and
  // the final B5/T sums, all from registered operands.
  always_comb begin
    diff_d   = signed'({1'b0, ut_q}) - signed'({1'b0, ac6_q});
    prod_d   = diff_d * signed'({1'b0, ac5_q});
    x1_d     = 32'(prod_d >>> 15);
    num_d    = {{5{mc_q[15]}}, mc_q, 11'b0};
    den_d    = x1_d + {{16{md_q[15]}}, md_q};
    numMag_d = num_d[31] ? (32'd0 - num_d) : num_d;
    denMag_d = den_d[31] ? (32'd0 - den_d) : den_d;
    trial_d  = {rem_q, quo_q[31]};
    fit_d    = (trial_d >= {1'b0, dvs_q});
    if (zeroDiv_q) begin
      x2_d = 32'sd0;
    end else if (negQuo_q) begin
      x2_d = 32'sd0 - quo_q;
    end else begin
      x2_d = quo_q;
    end
    b5_d   = x1_q + x2_q;
    temp_d = 16'((b5_d + 32'sd8) >>> 4);
  end

  // Sequencer: latch operands, register X1, run 32 divide steps, sign the
  // quotient, then publish results with a one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ut_q      <= '0;
      ac5_q     <= '0;
      ac6_q     <= '0;
      mc_q      <= '0;
      md_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      negQuo_q  <= 1'b0;
      zeroDiv_q <= 1'b0;
      divCnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divErr_q  <= 1'b0;
      b5_q      <= '0;
      temp_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ut_q    <= ut;
            ac5_q   <= ac5;
            ac6_q   <= ac6;
            mc_q    <= mc;
            md_q    <= md;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          x1_q      <= x1_d;
          quo_q     <= numMag_d;
          rem_q     <= '0;
          dvs_q     <= denMag_d;
          negQuo_q  <= num_d[31] ^ den_d[31];
          zeroDiv_q <= (den_d == 32'sd0);
          divCnt_q  <= '0;
          state_q   <= DIV;
        end
        DIV: begin
          if (fit_d) begin
            rem_q <= 32'(trial_d - {1'b0, dvs_q});
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= trial_d[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          divCnt_q <= divCnt_q + 5'd1;
          if (divCnt_q == 5'd31) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          x2_q    <= x2_d;
          state_q <= FIN;
        end
        FIN: begin
          b5_q     <= b5_d;
          temp_q   <= temp_d;
          divErr_q <= zeroDiv_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign div_err = divErr_q;
  assign b5      = b5_q;
  assign temp    = temp_q;

endmodule
